// File: rtl/fpu_round_pack.sv
// fpu_round_pack: normalises an extended mantissa/exponent pair, rounds it
// to nearest-even and packs the result into an IEEE-754 single.
module fpu_round_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [27:0] in_mant,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sign;
    logic signed [11:0] r_exp;
    logic [27:0]        r_mant;
    logic [31:0]        r_result;
    logic               r_ovf;
    logic               r_unf;
    logic               r_inx;

    logic               w_special;
    logic               w_mant_zero;
    logic               w_norm_exit;
    logic [27:0]        w_norm_mant;
    logic signed [11:0] w_norm_exp;

    logic               w_grs;
    logic               w_inc;
    logic [24:0]        w_sum;
    logic [23:0]        w_rmant;
    logic signed [11:0] w_rexp;
    logic               w_hidden;
    logic               w_ovf;

    assign w_special   = in_nan | in_inf | in_zero;
    assign w_mant_zero = (r_mant == 28'h0);

    // One normalisation step per cycle; earlier rules take precedence.
    always_comb begin
        w_norm_mant = r_mant;
        w_norm_exp  = r_exp;
        w_norm_exit = 1'b0;
        if (w_mant_zero) begin
            w_norm_exit = 1'b0;
        end else if (r_mant[27]) begin
            w_norm_mant = {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            w_norm_exp  = r_exp + 12'sd1;
        end else if (r_exp <= -12'sd25) begin
            w_norm_mant = {27'h0, |r_mant};
            w_norm_exp  = 12'sd1;
        end else if (r_exp < 12'sd1) begin
            w_norm_mant = {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            w_norm_exp  = r_exp + 12'sd1;
        end else if (!r_mant[26] && (r_exp > 12'sd1)) begin
            w_norm_mant = {r_mant[26:0], 1'b0};
            w_norm_exp  = r_exp - 12'sd1;
        end else begin
            w_norm_exit = 1'b1;
        end
    end

    assign w_grs    = |r_mant[2:0];
    assign w_inc    = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    assign w_sum    = {1'b0, r_mant[26:3]} + {24'h0, w_inc};
    assign w_rmant  = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
    assign w_rexp   = w_sum[24] ? (r_exp + 12'sd1) : r_exp;
    assign w_hidden = w_rmant[23];
    assign w_ovf    = (w_rexp >= 12'sd255);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_special ? OUT : NORM;
                end
            end
            NORM: begin
                if (w_mant_zero) begin
                    w_state_nxt = OUT;
                end else if (w_norm_exit) begin
                    w_state_nxt = ROUND;
                end
            end
            ROUND: w_state_nxt = OUT;
            OUT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = rst_n && (r_state == IDLE);
        out_valid     = (r_state == OUT);
        out_result    = r_result;
        out_overflow  = r_ovf;
        out_underflow = r_unf;
        out_inexact   = r_inx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_exp    <= 12'sd0;
            r_mant   <= 28'h0;
            r_result <= 32'h0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= in_sign;
                        r_exp  <= {{2{in_exp[9]}}, in_exp};
                        r_mant <= in_mant;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_inx  <= 1'b0;
                        if (in_nan) begin
                            r_result <= 32'h7FC00000;
                        end else if (in_inf) begin
                            r_result <= {in_sign, 8'hFF, 23'h0};
                        end else if (in_zero) begin
                            r_result <= {in_sign, 31'h0};
                        end
                    end
                end
                NORM: begin
                    if (w_mant_zero) begin
                        r_result <= {r_sign, 31'h0};
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                        r_inx    <= 1'b0;
                    end else begin
                        r_mant <= w_norm_mant;
                        r_exp  <= w_norm_exp;
                    end
                end
                ROUND: begin
                    if (w_ovf) begin
                        r_result <= {r_sign, 8'hFF, 23'h0};
                    end else begin
                        r_result <= {r_sign,
                                     w_hidden ? w_rexp[7:0] : 8'h00,
                                     w_rmant[22:0]};
                    end
                    r_ovf <= w_ovf;
                    r_inx <= w_ovf | w_grs;
                    r_unf <= w_grs & ~w_hidden & ~w_ovf;
                end
                OUT: begin
                    r_ovf <= r_ovf;
                end
                default: begin
                    r_ovf <= r_ovf;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Bench for fpu_round_pack: directed cases, specials, backpressure,
// reset abort and random operands against an exact-value RNE model.
module tb_fpu_round_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = 10'h0;
    logic [27:0] in_mant = 28'h0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int total = 0;
    int bad = 0;

    fpu_round_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .in_zero       (in_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    // Value = mant * 2^(exp-153); round that exact value to single precision.
    task automatic model(input bit sg, input logic [9:0] ex,
                         input logic [27:0] mt, input bit nan, input bit inf,
                         input bit zero, output logic [31:0] res,
                         output logic [2:0] flg);
        int     e;
        int     p;
        int     b;
        int     be;
        int     s;
        int     sh;
        longint q;
        longint rem;
        longint half;
        bit     inx;
        bit     hid;
        logic [7:0] ef;
        flg = 3'b000;
        inx = 1'b0;
        if (nan) res = 32'h7FC00000;
        else if (inf) res = {sg, 8'hFF, 23'h0};
        else if (zero) res = {sg, 31'h0};
        else if (mt == 28'h0) res = {sg, 31'h0};
        else begin
            e = $signed(ex);
            p = -1;
            for (int i = 0; i < 28; i++) if (mt[i]) p = i;
            b  = p + e - 26;
            be = (b < 1) ? 1 : b;
            s  = e - 3 - be;
            if (s >= 0) begin
                q = longint'(mt) << s;
            end else begin
                sh = -s;
                if (sh > 40) begin
                    q   = 0;
                    inx = 1'b1;
                end else begin
                    rem  = longint'(mt) & ((64'sd1 <<< sh) - 1);
                    half = 64'sd1 <<< (sh - 1);
                    q    = longint'(mt) >> sh;
                    inx  = (rem != 0);
                    if (rem > half || (rem == half && (q & 1) != 0)) q = q + 1;
                end
            end
            if (q >= (64'sd1 <<< 24)) begin
                q  = q >> 1;
                be = be + 1;
            end
            if (be >= 255) begin
                res = {sg, 8'hFF, 23'h0};
                flg = 3'b101;
            end else begin
                hid = q[23];
                ef  = hid ? be[7:0] : 8'h00;
                res = {sg, ef, q[22:0]};
                flg = {1'b0, inx & ~hid, inx};
            end
        end
    endtask

    task automatic run_op(input bit sg, input logic [9:0] ex,
                          input logic [27:0] mt, input bit nan,
                          input bit inf, input bit zero,
                          output logic [31:0] res, output logic [2:0] flg,
                          output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        in_sign  = sg;
        in_exp   = ex;
        in_mant  = mt;
        in_nan   = nan;
        in_inf   = inf;
        in_zero  = zero;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        flg = {out_overflow, out_underflow, out_inexact};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic gen(output bit sg, output logic [9:0] ex,
                       output logic [27:0] mt, output bit nan,
                       output bit inf, output bit zero);
        int k;
        sg   = 1'($urandom);
        nan  = 1'b0;
        inf  = 1'b0;
        zero = 1'b0;
        k = $urandom_range(0, 3);
        if (k == 0) ex = 10'($urandom);
        else if (k == 1) ex = 10'($urandom_range(0, 60) - 30);
        else if (k == 2) ex = 10'($urandom_range(100, 160));
        else ex = 10'($urandom_range(240, 262));
        k = $urandom_range(0, 9);
        if (k < 4) mt = 28'($urandom);
        else if (k < 7) mt = {2'b01, 26'($urandom)};
        else if (k == 7) mt = 28'($urandom) >> $urandom_range(1, 27);
        else if (k == 8) mt = {1'b1, 27'($urandom)};
        else mt = 28'h0;
        if ($urandom_range(0, 11) == 0) begin
            nan  = 1'($urandom);
            inf  = 1'($urandom);
            zero = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_hs got=%b exp=00", {out_valid, in_ready});
        end
        total++;
        if ({out_result, out_overflow, out_underflow, out_inexact} !== 35'h0) begin
            bad++;
            $display("FAIL reset_out got=%h exp=0", out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release got=%b exp=10", {in_ready, out_valid});
        end
    endtask

    task automatic test_directed();
        logic [9:0]  ex[8] = '{10'd127, 10'd127, 10'd127, 10'd127,
                               10'd254, 10'd127, 10'd0, 10'd0};
        logic [27:0] mt[8] = '{28'h4000000, 28'h8000000, 28'h4000004,
                               28'h400000C, 28'h7FFFFFF, 28'h0,
                               28'h4000000, 28'h7FFFFFF};
        bit          sg[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        logic [31:0] er[8] = '{32'h3F800000, 32'h40000000, 32'h3F800000,
                               32'h3F800002, 32'h7F800000, 32'h80000000,
                               32'h00400000, 32'h00800000};
        logic [2:0]  ef[8] = '{3'b000, 3'b000, 3'b001, 3'b001,
                               3'b101, 3'b000, 3'b000, 3'b001};
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(sg[i], ex[i], mt[i], 0, 0, 0, res, flg, lat);
            total++;
            if (res !== er[i] || flg !== ef[i] || lat < 2 || lat > 29) begin
                bad++;
                $display("FAIL directed%0d got=%h/%b lat=%0d exp=%h/%b",
                         i, res, flg, lat, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_special();
        bit          fl[5][3] = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1},
                                  '{1, 1, 1}, '{0, 1, 1}};
        bit          sg[5] = '{1, 1, 1, 0, 0};
        logic [31:0] er[5] = '{32'h7FC00000, 32'hFF800000, 32'h80000000,
                               32'h7FC00000, 32'h7F800000};
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(sg[i], 10'd127, 28'h4000004, fl[i][0], fl[i][1],
                   fl[i][2], res, flg, lat);
            total++;
            if (res !== er[i] || flg !== 3'b000 || lat != 1) begin
                bad++;
                $display("FAIL special%0d got=%h/%b lat=%0d exp=%h/000 lat=1",
                         i, res, flg, lat, er[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        int seen;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        in_nan   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_nan   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inf   = 1'b1;
            total++;
            if ({out_valid, in_ready} !== 2'b10 || out_result !== 32'h7FC00000) begin
                bad++;
                $display("FAIL hold%0d got=%b/%h exp=10/7fc00000",
                         i, {out_valid, in_ready}, out_result);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_inf    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL release got=%b exp=01", {out_valid, in_ready});
        end
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL ignored_in got=%0d exp=0", seen);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        int          seen;
        run_op(0, 10'd127, 28'h400000C, 0, 0, 0, res, flg, lat);
        in_exp   = 10'd127;
        in_mant  = 28'h0000008;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b00 || out_result !== 32'h0 ||
            {out_overflow, out_underflow, out_inexact} !== 3'b000) begin
            bad++;
            $display("FAIL midreset got=%b/%h exp=00/00000000",
                     {out_valid, in_ready}, out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_ready got=%b exp=1", in_ready);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL stale got=%0d exp=0", seen);
        end
        run_op(0, 10'd127, 28'h4000000, 0, 0, 0, res, flg, lat);
        total++;
        if (res !== 32'h3F800000 || flg !== 3'b000) begin
            bad++;
            $display("FAIL post_reset got=%h/%b exp=3f800000/000", res, flg);
        end
    endtask

    task automatic test_random();
        bit          sg, nan, inf, zero;
        logic [9:0]  ex;
        logic [27:0] mt;
        logic [31:0] res, er;
        logic [2:0]  flg, ef;
        int          lat;
        bit          sp;
        for (int i = 0; i < 300; i++) begin
            gen(sg, ex, mt, nan, inf, zero);
            model(sg, ex, mt, nan, inf, zero, er, ef);
            sp = nan | inf | zero;
            run_op(sg, ex, mt, nan, inf, zero, res, flg, lat);
            total++;
            if (res !== er || flg !== ef ||
                (sp && lat != 1) || (!sp && (lat < 2 || lat > 29))) begin
                bad++;
                $display("FAIL rand%0d e=%h m=%h got=%h/%b lat=%0d exp=%h/%b",
                         i, ex, mt, res, flg, lat, er, ef);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          sg, nan, inf, zero;
        logic [9:0]  ex;
        logic [27:0] mt;
        logic [31:0] res, er;
        logic [2:0]  flg, ef;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            gen(sg, ex, mt, nan, inf, zero);
            model(sg, ex, mt, nan, inf, zero, er, ef);
            run_op(sg, ex, mt, nan, inf, zero, res, flg, lat);
            total++;
            if (res !== er || flg !== ef ||
                {in_ready, out_valid} !== 2'b10) begin
                bad++;
                $display("FAIL b2b%0d got=%h/%b hs=%b exp=%h/%b hs=10",
                         i, res, flg, {in_ready, out_valid}, er, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_round_pack.md
FPU_ROUND_PACK -- requirements
Module: fpu_round_pack

Interface
REQ-001 SHALL have ports, clock and reset first, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand.
- in_sign  in  1  result sign.
- in_exp  in  10  biased exponent, two's complement, range -512..511.
- in_mant  in  28  [27] overflow bit, [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- in_nan, in_inf, in_zero  in  1 each  special-result requests; priority nan > inf > zero.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  packed IEEE-754 single: sign, exp[7:0], frac[22:0].
- out_overflow, out_underflow, out_inexact  out  1 each  exception flags, valid with out_valid.
REQ-002 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-003 SHALL implement FSM states IDLE, NORM, ROUND, OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-004 IDLE, in_valid=1: SHALL capture all inputs and go to OUT if any special flag is set, else to NORM.
REQ-005 Special results SHALL be: nan -> 32'h7FC00000 (sign ignored); inf -> {sign,8'hFF,23'h0}; zero -> {sign,31'h0}; all flags 0.
REQ-006 NORM SHALL perform exactly one action per cycle, first matching rule wins:
- mant==0 -> result {sign,31'h0}, flags 0, go to OUT.
- mant[27]=1 -> shift right 1, new bit0 = old bit1 | old bit0, exp+1.
- exp <= -25 -> mant={27'h0, |mant}, exp=1.
- exp < 1 -> shift right 1 with sticky OR, exp+1.
- mant[26]=0 and exp > 1 -> shift left 1, exp-1.
- otherwise go to ROUND.
REQ-007 NORM SHALL finish in at most 28 cycles for any input.
REQ-008 ROUND SHALL round to nearest even: inc = G & (R | S | mant[3]); 24-bit sum = mant[26:3] + inc.
REQ-009 A carry out of the sum SHALL shift the sum right 1 and add 1 to exp.
REQ-010 Exponent field SHALL be exp[7:0] if the rounded hidden bit is 1, else 0 (subnormal or zero); a subnormal rounding into bit 23 SHALL yield exponent field 1.
REQ-011 After rounding, exp >= 255 SHALL give {sign,8'hFF,23'h0} with out_overflow=1 and out_inexact=1.
REQ-012 out_inexact SHALL be G|R|S as seen in ROUND.
REQ-013 out_underflow SHALL be 1 iff out_inexact=1 and the rounded hidden bit is 0.
REQ-014 Go to OUT after ROUND; out_result and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 OUT with out_ready=1: SHALL go to IDLE on that edge; the next operand is accepted no earlier than the following cycle. There is no same-cycle pass-through.
REQ-016 Latency SHALL be:
- special input: out_valid asserted 1 cycle after the accept edge.
- normal input: 1 + N + 1 cycles, where N is the number of NORM cycles including the exit cycle.
REQ-017 in_valid while not in IDLE SHALL be ignored; the upstream block holds its data until in_ready.

Reset
REQ-018 rst_n low SHALL immediately force: state IDLE, out_valid=0, out_result=32'h0, all flags 0, internal registers 0.
REQ-019 While rst_n is low, in_ready SHALL be 0; it becomes 1 in the first cycle after deassertion.
REQ-020 Reset mid-operation SHALL discard the operation, and no result SHALL be emitted for it.

Verification
REQ-021 in_exp=127, in_mant=28'h4000000, sign 0 -> out_result=32'h3F800000; flags 0.
REQ-022 in_exp=127, in_mant=28'h8000000 -> one right shift, out_result=32'h40000000.
REQ-023 Round-to-even:
- in_mant=28'h4000004, exp 127 -> 32'h3F800000, inexact=1.
- in_mant=28'h400000C, exp 127 -> 32'h3F800002, inexact=1.
REQ-024 in_exp=254, in_mant=28'h7FFFFFF -> 32'h7F800000, overflow=1, inexact=1.
REQ-025 in_nan=1 with out_ready held 0 for 5 cycles -> out_result=32'h7FC00000, stable; in_ready=0 throughout; IDLE after the out_ready=1 edge.
REQ-026 in_exp=127, in_mant=28'h0000008; assert rst_n low during NORM -> out_valid=0 and out_result=0 at once; in_ready=1 the cycle after release; no stale result.
